// File: rtl/i2c_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_sequencer_if
// Description : Command bus between the command sequencer and the I2C master.
//               The sequencer presents the operands (addr/data/rw) and a
//               toggle-style send strobe. The master reports busy back.
//   addr  7  slave address of the current command
//   data  8  data byte of the current command
//   rw    1  0 = write, 1 = read
//   send  1  toggles once per command
//   busy  1  master busy (slow clock domain)
//   modport master : sequencer side (drives operands/send, reads busy)
//   modport slave  : I2C master side (reads operands/send, drives busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_cmd_sequencer_if;
  logic [6:0] addr;
  logic [7:0] data;
  logic       rw;
  logic       send;
  logic       busy;

  modport master (output addr, output data, output rw, output send, input busy);
  modport slave  (input addr, input data, input rw, input send, output busy);
endinterface
`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_sequencer
// Description : Holds a small table of I2C write/read commands and issues them
//               one by one to the I2C master after a single start pulse.
//               Each command: load operands, toggle send one cycle later, wait
//               for the master's busy to rise and fall, idle GAP_CYC cycles.
//               Optional macro TIMEOUT_EN adds a per-edge busy timeout that
//               aborts the sequence with a sticky err flag.
// Ports       : CLOCK_50  in   system clock
//               rst_n     in   asynchronous active-low reset
//               tbl_we    in   table write strobe (honoured only when idle)
//               tbl_idx   in   table write index
//               tbl_addr  in   entry slave address
//               tbl_data  in   entry data byte
//               tbl_rw    in   entry rw bit
//               num_cmd   in   number of entries to run, sampled on start
//               start     in   launch pulse
//               bus       if   master modport: addr/data/rw/send out, busy in
//               seq_busy  out  sequence in progress
//               done      out  one-cycle pulse on clean completion
//               err       out  sticky timeout flag (0 without TIMEOUT_EN)
//               cmd_idx   out  index of command currently/last issued
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_sequencer #(
  parameter  int DEPTH       = 8,
  parameter  int GAP_CYC     = 1000,
  parameter  int TIMEOUT_CYC = 50000000,
  localparam int IW          = $clog2(DEPTH)
) (
  input  wire                  CLOCK_50,
  input  wire                  rst_n,
  input  wire                  tbl_we,
  input  wire  [IW-1:0]        tbl_idx,
  input  wire  [6:0]           tbl_addr,
  input  wire  [7:0]           tbl_data,
  input  wire                  tbl_rw,
  input  wire  [IW:0]          num_cmd,
  input  wire                  start,
  i2c_cmd_sequencer_if.master  bus,
  output logic                 seq_busy,
  output logic                 done,
  output logic                 err,
  output logic [IW-1:0]        cmd_idx
);

  localparam logic [IW:0] c_DEPTH_W  = (IW+1)'(DEPTH);
  // The WAIT_LO cycle that first sees busy_s low is the first idle cycle,
  // so the GAP state itself lasts GAP_CYC-1 cycles (at least one).
  localparam logic [31:0] c_GAP_LAST = (GAP_CYC > 1) ? 32'(GAP_CYC - 2) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_KICK    = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_GAP     = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [6:0]    r_tbl_addr [DEPTH];
  logic [7:0]    r_tbl_data [DEPTH];
  logic          r_tbl_rw   [DEPTH];

  logic          r_busy_meta;
  logic          r_busy_s;
  logic [6:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_rw;
  logic          r_send;
  logic [IW-1:0] r_cmd_idx;
  logic [IW:0]   r_num;
  logic [31:0]   r_gap;

  logic          w_gap_end;
  logic          w_last;
  logic          w_timeout;
  logic [IW:0]   w_num_clamped;

  assign w_gap_end     = (r_gap == c_GAP_LAST);
  assign w_last        = ({1'b0, r_cmd_idx} == (r_num - 1'b1));
  assign w_num_clamped = (num_cmd > c_DEPTH_W) ? c_DEPTH_W : num_cmd;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // Next-state logic. A busy_s already high on WAIT_HI entry simply moves on
  // to WAIT_LO, so a stale busy never causes a second send toggle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = (num_cmd != '0) ? S_LOAD : S_DONE;
      S_LOAD:    w_state_next = S_KICK;
      S_KICK:    w_state_next = S_WAIT_HI;
      S_WAIT_HI: if (w_timeout)     w_state_next = S_ERR;
                 else if (r_busy_s) w_state_next = S_WAIT_LO;
      S_WAIT_LO: if (w_timeout)      w_state_next = S_ERR;
                 else if (!r_busy_s) w_state_next = S_GAP;
      S_GAP:     if (w_gap_end) w_state_next = w_last ? S_DONE : S_LOAD;
      S_DONE:    w_state_next = S_IDLE;
      S_ERR:     w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: synchronizer, command table, operand/send registers, counters
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_meta <= 1'b0;
      r_busy_s    <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rw        <= 1'b0;
      r_send      <= 1'b0;
      r_cmd_idx   <= '0;
      r_num       <= '0;
      r_gap       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl_addr[i] <= '0;
        r_tbl_data[i] <= '0;
        r_tbl_rw[i]   <= 1'b0;
      end
    end else begin
      r_busy_meta <= bus.busy;
      r_busy_s    <= r_busy_meta;
      case (r_state)
        S_IDLE: begin
          if (tbl_we && ({1'b0, tbl_idx} < c_DEPTH_W)) begin
            r_tbl_addr[tbl_idx] <= tbl_addr;
            r_tbl_data[tbl_idx] <= tbl_data;
            r_tbl_rw[tbl_idx]   <= tbl_rw;
          end
          if (start && (num_cmd != '0)) begin
            r_num     <= w_num_clamped;
            r_cmd_idx <= '0;
          end
        end
        S_LOAD: begin
          r_addr <= r_tbl_addr[r_cmd_idx];
          r_data <= r_tbl_data[r_cmd_idx];
          r_rw   <= r_tbl_rw[r_cmd_idx];
        end
        S_KICK:    r_send <= ~r_send;
        S_WAIT_LO: r_gap  <= '0;
        S_GAP: begin
          r_gap <= r_gap + 32'd1;
          if (w_gap_end && !w_last) r_cmd_idx <= r_cmd_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef TIMEOUT_EN
  localparam logic [31:0] c_TO_LAST = 32'(TIMEOUT_CYC - 1);

  logic [31:0] r_to_cnt;
  logic        r_err;

  // Restarts on every entry into WAIT_HI or WAIT_LO, so each busy edge gets
  // its own full TIMEOUT_CYC budget.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((w_state_next == S_WAIT_HI || w_state_next == S_WAIT_LO) &&
                 (w_state_next == r_state)) begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)                              r_err <= 1'b0;
    else if (r_state == S_IDLE && start)     r_err <= 1'b0;
    else if (w_state_next == S_ERR)          r_err <= 1'b1;
  end

  assign w_timeout = (r_to_cnt == c_TO_LAST);
  assign err       = r_err;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYC);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  assign bus.addr = r_addr;
  assign bus.data = r_data;
  assign bus.rw   = r_rw;
  assign bus.send = r_send;
  assign cmd_idx  = r_cmd_idx;
  assign done     = (r_state == S_DONE);
  assign seq_busy = (r_state inside {S_LOAD, S_KICK, S_WAIT_HI, S_WAIT_LO, S_GAP});

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_cmd_sequencer
// Description : Self-checking bench for i2c_cmd_sequencer. A behavioural I2C
//               master answers each send toggle with a busy pulse (rises 3
//               slow ticks after the toggle, lasts 20 ticks). A table model
//               predicts which commands must appear on the bus, how many
//               toggles and done pulses occur, and the inter-command timing.
//               The TIMEOUT_EN section runs only when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_sequencer;
  localparam int DEPTH       = 8;
  localparam int IW          = 3;
  localparam int GAP_CYC     = 1000;
  localparam int TIMEOUT_CYC = 100;
  localparam int TICK        = 4;    // CLOCK_50 cycles per slow tick

  logic          CLOCK_50 = 1'b0;
  logic          rst_n    = 1'b0;
  logic          tbl_we   = 1'b0;
  logic [IW-1:0] tbl_idx  = '0;
  logic [6:0]    tbl_addr = '0;
  logic [7:0]    tbl_data = '0;
  logic          tbl_rw   = 1'b0;
  logic [IW:0]   num_cmd  = '0;
  logic          start    = 1'b0;
  logic          seq_busy;
  logic          done;
  logic          err;
  logic [IW-1:0] cmd_idx;

  i2c_cmd_sequencer_if bus ();

  i2c_cmd_sequencer #(
    .DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_rw(tbl_rw),
    .num_cmd(num_cmd), .start(start), .bus(bus), .seq_busy(seq_busy),
    .done(done), .err(err), .cmd_idx(cmd_idx)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int sb_cnt = 0;
  int toggle_cnt = 0;
  bit master_en = 1'b1;

  logic [6:0] m_addr [DEPTH];
  logic [7:0] m_data [DEPTH];
  logic       m_rw   [DEPTH];

  logic [15:0] cap_rise_q [$];
  logic [15:0] cap_fall_q [$];
  int          tog_cyc_q  [$];
  int          fall_cyc_q [$];

  always @(posedge CLOCK_50) cyc <= cyc + 1;
  always @(negedge CLOCK_50) begin
    if (done === 1'b1)     done_cnt <= done_cnt + 1;
    if (seq_busy === 1'b1) sb_cnt   <= sb_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural I2C master: reacts to each send toggle with one busy pulse.
  initial begin : master_model
    logic prev_send;
    prev_send = 1'b0;
    bus.busy  = 1'b0;
    forever begin
      @(posedge CLOCK_50); #1;
      if (!rst_n) begin
        prev_send = bus.send;
        bus.busy  = 1'b0;
      end else if (bus.send !== prev_send) begin
        prev_send = bus.send;
        toggle_cnt++;
        tog_cyc_q.push_back(cyc);
        if (master_en) begin
          for (int k = 0; k < 3*TICK && rst_n; k++) @(posedge CLOCK_50);
          #1;
          if (rst_n) begin
            bus.busy = 1'b1;
            cap_rise_q.push_back({bus.addr, bus.data, bus.rw});
            for (int k = 0; k < 20*TICK && rst_n; k++) @(posedge CLOCK_50);
            #1;
            if (rst_n) begin
              cap_fall_q.push_back({bus.addr, bus.data, bus.rw});
              fall_cyc_q.push_back(cyc);
            end
            bus.busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(20 * 120000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_entry(input int idx, input logic [6:0] a, input logic [7:0] d, input logic r);
    @(posedge CLOCK_50); #1;
    tbl_we = 1'b1; tbl_idx = idx[IW-1:0]; tbl_addr = a; tbl_data = d; tbl_rw = r;
    @(posedge CLOCK_50); #1;
    tbl_we = 1'b0;
    if (idx < DEPTH) begin
      m_addr[idx] = a; m_data[idx] = d; m_rw[idx] = r;
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge CLOCK_50); #1;
    start = 1'b1; num_cmd = n[IW:0];
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  task automatic clear_capture();
    cap_rise_q.delete(); cap_fall_q.delete();
    tog_cyc_q.delete();  fall_cyc_q.delete();
  endtask

  // Runs one sequence and checks it against the table model. With inject set,
  // a second start and a table write are attempted while the first command is
  // in flight; both must be ignored.
  task automatic run_seq(input int n_req, input string tag, input bit inject);
    int n_exp, t0, d0, w;
    logic [15:0] exp_q [$];
    n_exp = (n_req > DEPTH) ? DEPTH : n_req;
    for (int i = 0; i < n_exp; i++) exp_q.push_back({m_addr[i], m_data[i], m_rw[i]});
    clear_capture();
    t0 = toggle_cnt; d0 = done_cnt;
    pulse_start(n_req);
    if (inject) begin
      w = 0;
      while (cap_rise_q.size() == 0 && w < 2000) begin @(posedge CLOCK_50); w++; end
      check({tag, "_inject_reach"}, 32'(cap_rise_q.size() != 0), 32'd1);
      @(posedge CLOCK_50); #1;
      start = 1'b1; num_cmd = 1;
      tbl_we = 1'b1; tbl_idx = 0; tbl_addr = 7'h7F; tbl_data = 8'hEE; tbl_rw = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0; tbl_we = 1'b0;
    end
    w = 0;
    while (done !== 1'b1 && w < n_exp * (GAP_CYC + 200) + 200) begin
      @(negedge CLOCK_50); w++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    repeat (5) @(negedge CLOCK_50);
    check({tag, "_toggles"},  32'(toggle_cnt - t0), 32'(n_exp));
    check({tag, "_done_cnt"}, 32'(done_cnt - d0),   32'd1);
    check({tag, "_err"},      32'(err),             32'd0);
    check({tag, "_seq_busy"}, 32'(seq_busy),        32'd0);
    check({tag, "_ncap"},     32'(cap_rise_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      check($sformatf("%s_cmd%0d_rise", tag, i),
            32'((i < cap_rise_q.size()) ? cap_rise_q[i] : 16'hxxxx), 32'(exp_q[i]));
      check($sformatf("%s_cmd%0d_fall", tag, i),
            32'((i < cap_fall_q.size()) ? cap_fall_q[i] : 16'hxxxx), 32'(exp_q[i]));
    end
    // busy_s trails the raw busy drop by two edges; from there the next toggle
    // follows after GAP_CYC idle cycles plus LOAD and KICK.
    for (int i = 0; i + 1 < n_exp; i++) begin
      check($sformatf("%s_gap%0d", tag, i),
            32'(((i + 1 < tog_cyc_q.size()) && (i < fall_cyc_q.size())) ?
                (tog_cyc_q[i+1] - fall_cyc_q[i]) : -1),
            32'(2 + GAP_CYC + 2));
    end
  endtask

  initial begin : main
    int t0, d0, s0, w;
    for (int i = 0; i < DEPTH; i++) begin m_addr[i] = '0; m_data[i] = '0; m_rw[i] = 1'b0; end

    // Reset state
    repeat (3) @(posedge CLOCK_50); #1;
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_rw",   32'(bus.rw),   32'd0);
    check("rst_send", 32'(bus.send), 32'd0);
    check("rst_seq_busy", 32'(seq_busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_cmd_idx", 32'(cmd_idx), 32'd0);
    rst_n = 1'b1;

    // Directed three-command sequence
    write_entry(0, 7'h1A, 8'h0F, 1'b0);
    write_entry(1, 7'h1A, 8'h80, 1'b0);
    write_entry(2, 7'h34, 8'h55, 1'b1);
    run_seq(3, "dir3", 1'b0);

    // num_cmd = 0: done the cycle after start, nothing else happens
    t0 = toggle_cnt; d0 = done_cnt; s0 = sb_cnt;
    pulse_start(0);
    @(negedge CLOCK_50);
    check("zero_done_pulse", 32'(done), 32'd1);
    @(negedge CLOCK_50);
    check("zero_done_low", 32'(done), 32'd0);
    repeat (5) @(negedge CLOCK_50);
    check("zero_toggles",  32'(toggle_cnt - t0), 32'd0);
    check("zero_seq_busy", 32'(sb_cnt - s0),     32'd0);
    check("zero_done_cnt", 32'(done_cnt - d0),   32'd1);

    // Mid-sequence start and table write are ignored; entry 0 keeps 0x1A
    run_seq(3, "inject", 1'b1);
    run_seq(1, "tbl0_kept", 1'b0);

    // Randomized tables and lengths, then a clamped length
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(3, 8))
        write_entry($urandom_range(0, DEPTH-1), 7'($urandom), 8'($urandom), 1'($urandom));
      run_seq($urandom_range(1, 6), $sformatf("rand%0d", r), 1'b0);
    end
    for (int i = 0; i < DEPTH; i++)
      write_entry(i, 7'($urandom), 8'($urandom), 1'($urandom));
    run_seq(12, "clamp", 1'b0);

    // Reset during WAIT_LO of command 1
    write_entry(0, 7'h21, 8'h11, 1'b0);
    write_entry(1, 7'h42, 8'h22, 1'b1);
    clear_capture();
    pulse_start(3);
    w = 0;
    while (cap_rise_q.size() < 2 && w < 3000) begin @(posedge CLOCK_50); w++; end
    check("arst_reach_cmd1", 32'(cap_rise_q.size()), 32'd2);
    repeat (10) @(posedge CLOCK_50);
    check("arst_pre_idx", 32'(cmd_idx), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_addr", 32'(bus.addr), 32'd0);
    check("arst_data", 32'(bus.data), 32'd0);
    check("arst_rw",   32'(bus.rw),   32'd0);
    check("arst_send", 32'(bus.send), 32'd0);
    check("arst_seq_busy", 32'(seq_busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_cmd_idx", 32'(cmd_idx), 32'd0);
    repeat (3) @(posedge CLOCK_50); #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin m_addr[i] = '0; m_data[i] = '0; m_rw[i] = 1'b0; end
    run_seq(2, "post_rst", 1'b0);

`ifdef TIMEOUT_EN
    // Master never answers: err after TIMEOUT_CYC, no done, cmd_idx 0
    master_en = 1'b0;
    clear_capture();
    d0 = done_cnt;
    pulse_start(1);
    w = 0;
    while (tog_cyc_q.size() == 0 && w < 100) begin @(posedge CLOCK_50); w++; end
    check("to_toggle", 32'(tog_cyc_q.size()), 32'd1);
    w = 0;
    while (err !== 1'b1 && w < 10 * TIMEOUT_CYC) begin @(posedge CLOCK_50); #1; w++; end
    check("to_err", 32'(err), 32'd1);
    check("to_latency_window",
          32'((tog_cyc_q.size() != 0) &&
              (cyc - tog_cyc_q[0] >= TIMEOUT_CYC - 1) &&
              (cyc - tog_cyc_q[0] <= TIMEOUT_CYC + 3)), 32'd1);
    check("to_cmd_idx", 32'(cmd_idx), 32'd0);
    repeat (5) @(negedge CLOCK_50);
    check("to_seq_busy", 32'(seq_busy), 32'd0);
    check("to_no_done", 32'(done_cnt - d0), 32'd0);
    check("to_err_sticky", 32'(err), 32'd1);
    master_en = 1'b1;
    run_seq(1, "to_recover", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
